pwm_gen: RTL and testbench
==========================

// Module: pwm_gen
// PURPOSE
//  Synthesizable PWM gate-drive generator; upstream stage of the rectifier input-switch/filter model.
//  Produces ctrl (drives the +/-1.0 square-wave source feeding filter) and complementary ctrl_n.
//  Period and duty are programmed at runtime via a valid/ready config port.
//  New settings are shadowed and applied only at period boundaries (glitch-free).
// PARAMETERS
//  CNT_W        16   width of counter, period and duty fields
//  INIT_PERIOD  100  period (cycles) loaded at reset; clamped to >=2
//  INIT_DUTY    50   high-time (cycles) loaded at reset
//  DEAD_CYCLES  2    dead-time inserted on each rising edge (PWM_DEADTIME_EN only); 0 allowed
// PORTS
//  emu_clk      in   1      emulation clock
//  emu_rst      in   1      asynchronous reset, active-high
//  enable       in   1      run request; low forces IDLE
//  cfg_valid    in   1      config word valid
//  cfg_ready    out  1      config word accepted when cfg_valid && cfg_ready
//  cfg_period   in   CNT_W  requested period in cycles
//  cfg_duty     in   CNT_W  requested high-time in cycles
//  ctrl         out  1      gate drive, high-side
//  ctrl_n       out  1      gate drive, low-side (complement)
//  period_start out  1      one-cycle pulse on first cycle of each period
//  cfg_applied  out  1      one-cycle pulse when shadow config becomes active
// BEHAVIOUR
//  Reset: cnt=0, period_r=max(INIT_PERIOD,2), duty_r=INIT_DUTY, pending=0, state=IDLE;
//   ctrl=0, ctrl_n=0, period_start=0, cfg_applied=0, cfg_ready=1. All outputs registered.
//  FSM: IDLE -> RUN when enable=1 sampled; RUN -> IDLE when enable=0 sampled (any cnt value).
//   IDLE: cnt held 0, ctrl=ctrl_n=period_start=0.
//   RUN: cnt counts 0..period_r-1 then wraps to 0; first RUN cycle has cnt=0.
//  Outputs (raw, aligned with cnt): raw = (cnt < duty_r); period_start = (cnt==0) in RUN.
//   duty_r=0 -> ctrl constantly 0; duty_r>=period_r -> ctrl constantly 1 (no edge at wrap).
//  Config handshake: cfg_ready = !pending. On accept: shadow <= {max(cfg_period,2), cfg_duty},
//   pending <= 1 (cfg_ready low next cycle). cfg_period 0 or 1 clamped to 2.
//  Apply: in RUN, shadow loads into period_r/duty_r on the wrap edge (cnt==period_r-1), so new
//   values govern the next period starting at cnt=0; in IDLE, load occurs the cycle after accept.
//   On load: pending<=0, cfg_applied pulses 1 cycle (aligned with cnt=0 of new period in RUN).
//  Accept and apply in the same cycle: apply uses old shadow, new word becomes pending (no loss).
//  Disable mid-period: next cycle IDLE, outputs 0, cnt=0; pending shadow applied in IDLE.
//  Reset mid-operation: immediate return to reset values; pending config discarded.
// CONFIGURATION
//  PWM_DEADTIME_EN defined: each rising edge of ctrl (raw 0->1) and of ctrl_n (!raw 0->1 in RUN)
//   delayed by DEAD_CYCLES; falling edges undelayed; ctrl && ctrl_n never both 1. A pulse
//   shorter than or equal to DEAD_CYCLES is suppressed entirely. Dead-time counter clears in IDLE.
//  PWM_DEADTIME_EN undefined: ctrl = raw, ctrl_n = !raw in RUN (0 in IDLE); DEAD_CYCLES ignored.
// TESTING
//  1 cfg period=10 duty=5 in IDLE, enable -> ctrl 5 high/5 low, period_start every 10 cycles.
//  2 RUN at 10/5, at cnt=4 send duty=3 -> current period 5 high; next period 3 high; cfg_applied
//    pulses at its cnt=0; cfg_ready low from accept until apply.
//  3 Two back-to-back cfg_valid words -> second stalls (cfg_ready=0) until first applied.
//  4 duty=0 -> ctrl stuck 0; duty=12 period=10 -> ctrl stuck 1; period=1 -> runs as period 2.
//  5 Assert emu_rst at cnt=6 with pending cfg -> all outputs 0, cfg_ready=1, INIT values restored.
//  6 PWM_DEADTIME_EN, DEAD_CYCLES=2, 10/5 -> ctrl high cnt 2..4, ctrl_n high cnt 7..9; never overlap.

Source files
------------

// File: rtl/pwm_gen.sv
// PWM gate-drive generator with shadowed period/duty config applied at period boundaries.
// Optional dead-time insertion on rising edges is enabled by defining PWM_DEADTIME_EN.
module pwm_gen #(
  parameter int CNT_W       = 16,
  parameter int INIT_PERIOD = 100,
  parameter int INIT_DUTY   = 50,
  parameter int DEAD_CYCLES = 2
) (
  input  logic             emu_clk,
  input  logic             emu_rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             ctrl,
  output logic             ctrl_n,
  output logic             period_start,
  output logic             cfg_applied
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A period below two cycles cannot produce both phases, so it is raised to two.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    if (p < CNT_W'(2)) begin
      return CNT_W'(2);
    end else begin
      return p;
    end
  endfunction

  localparam logic [CNT_W-1:0] INIT_P = (INIT_PERIOD < 2) ? CNT_W'(2) : CNT_W'(INIT_PERIOD);
  localparam logic [CNT_W-1:0] INIT_D = CNT_W'(INIT_DUTY);

  if (DEAD_CYCLES < 0) begin : g_dead_chk
    $error("pwm_gen: DEAD_CYCLES must be non-negative");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] period_r, period_next;
  logic [CNT_W-1:0] duty_r, duty_next;
  logic [CNT_W-1:0] shadow_period, shadow_period_next;
  logic [CNT_W-1:0] shadow_duty, shadow_duty_next;
  logic             pending, pending_next;
  logic             accept, wrap, apply;
  logic             raw_next, ctrl_next, ctrl_n_next;

  // Next-state, counter and config shadow/apply logic.
  always_comb begin
    state_next         = state;
    cnt_next           = cnt;
    period_next        = period_r;
    duty_next          = duty_r;
    shadow_period_next = shadow_period;
    shadow_duty_next   = shadow_duty;
    pending_next       = pending;
    accept             = cfg_valid && !pending;
    wrap               = (state == RUN) && (cnt == period_r - CNT_W'(1));
    apply              = pending && (wrap || (state == IDLE));

    case (state)
      IDLE:    state_next = enable ? RUN : IDLE;
      RUN:     state_next = enable ? RUN : IDLE;
      default: state_next = IDLE;
    endcase

    // Apply drains the old shadow before an accept in the same cycle refills it.
    if (apply) begin
      period_next  = shadow_period;
      duty_next    = shadow_duty;
      pending_next = 1'b0;
    end else begin
      period_next  = period_r;
      duty_next    = duty_r;
    end

    if (accept) begin
      shadow_period_next = clamp_period(cfg_period);
      shadow_duty_next   = cfg_duty;
      pending_next       = 1'b1;
    end else begin
      shadow_period_next = shadow_period;
      shadow_duty_next   = shadow_duty;
    end

    if ((state_next == IDLE) || (state == IDLE) || wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end

    raw_next = (state_next == RUN) && (cnt_next < duty_next);
  end

`ifdef PWM_DEADTIME_EN
  logic [CNT_W-1:0] hi_len, lo_len, hi_next, lo_next;

  // Run lengths of the raw high/low phases gate each rising edge by DEAD_CYCLES.
  always_comb begin
    hi_next = '0;
    lo_next = '0;
    if (state_next == RUN) begin
      if (raw_next) begin
        hi_next = (hi_len == '1) ? hi_len : hi_len + CNT_W'(1);
        lo_next = '0;
      end else begin
        hi_next = '0;
        lo_next = (lo_len == '1) ? lo_len : lo_len + CNT_W'(1);
      end
    end else begin
      hi_next = '0;
      lo_next = '0;
    end
    ctrl_next   = raw_next && (hi_next > CNT_W'(DEAD_CYCLES));
    ctrl_n_next = (state_next == RUN) && !raw_next && (lo_next > CNT_W'(DEAD_CYCLES));
  end

  // Dead-time run-length registers.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      hi_len <= '0;
      lo_len <= '0;
    end else begin
      hi_len <= hi_next;
      lo_len <= lo_next;
    end
  end
`else
  // Without dead-time the drives are the raw waveform and its complement.
  always_comb begin
    ctrl_next   = raw_next;
    ctrl_n_next = (state_next == RUN) && !raw_next;
  end
`endif

  // Core state, active config and shadow registers.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      period_r      <= INIT_P;
      duty_r        <= INIT_D;
      shadow_period <= INIT_P;
      shadow_duty   <= INIT_D;
      pending       <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      period_r      <= period_next;
      duty_r        <= duty_next;
      shadow_period <= shadow_period_next;
      shadow_duty   <= shadow_duty_next;
      pending       <= pending_next;
    end
  end

  // Outputs are registered from next-state values so they line up with cnt.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      ctrl         <= 1'b0;
      ctrl_n       <= 1'b0;
      period_start <= 1'b0;
      cfg_applied  <= 1'b0;
      cfg_ready    <= 1'b1;
    end else begin
      ctrl         <= ctrl_next;
      ctrl_n       <= ctrl_n_next;
      period_start <= (state_next == RUN) && (cnt_next == '0);
      cfg_applied  <= apply;
      cfg_ready    <= !pending_next;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen; expected waveforms are derived from the
// programmed period/duty and a tracked expected counter phase.
module tb_pwm_gen;

  localparam int CNT_W = 16;

  logic             emu_clk;
  logic             emu_rst;
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic             ctrl;
  logic             ctrl_n;
  logic             period_start;
  logic             cfg_applied;

  int n_tests;
  int n_fail;
  int ph;

  pwm_gen #(
    .CNT_W(CNT_W), .INIT_PERIOD(100), .INIT_DUTY(50), .DEAD_CYCLES(2)
  ) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .ctrl(ctrl), .ctrl_n(ctrl_n),
    .period_start(period_start), .cfg_applied(cfg_applied)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge emu_clk);
    #1;
  endtask

  // Advance n cycles in RUN, checking the waveform against the expected phase.
  task automatic run_cycles(input int n, input int per, input int dty, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle();
      ph = (ph >= per - 1) ? 0 : ph + 1;
      check({tag, "_ctrl"}, 32'(ctrl), 32'(ph < dty));
      check({tag, "_ctrl_n"}, 32'(ctrl_n), 32'(ph >= dty));
      check({tag, "_pstart"}, 32'(period_start), 32'(ph == 0));
    end
  endtask

  // Load a config word while IDLE and confirm it takes effect the following cycle.
  task automatic cfg_send_idle(input int p, input int d, input string tag);
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_duty   = CNT_W'(d);
    cycle();
    check({tag, "_rdy_low"}, 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    cycle();
    check({tag, "_applied"}, 32'(cfg_applied), 32'd1);
    check({tag, "_rdy_back"}, 32'(cfg_ready), 32'd1);
  endtask

  task automatic go_idle(input string tag);
    enable = 1'b0;
    cycle();
    check({tag, "_idle_ctrl"}, 32'(ctrl), 32'd0);
    check({tag, "_idle_ctrl_n"}, 32'(ctrl_n), 32'd0);
    check({tag, "_idle_pstart"}, 32'(period_start), 32'd0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    ph         = 0;
    emu_rst    = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;
    #1 emu_rst = 1'b1;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_ctrl_n", 32'(ctrl_n), 32'd0);
    check("rst_pstart", 32'(period_start), 32'd0);
    check("rst_applied", 32'(cfg_applied), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    cycle();
    emu_rst = 1'b0;
    cycle();

`ifdef PWM_DEADTIME_EN
    cfg_send_idle(10, 5, "dt_cfg");
    enable = 1'b1;
    ph = 9;
    for (int i = 0; i < 30; i++) begin
      cycle();
      ph = (ph >= 9) ? 0 : ph + 1;
      check("dt_ctrl", 32'(ctrl), 32'((ph >= 2) && (ph <= 4)));
      check("dt_ctrl_n", 32'(ctrl_n), 32'(ph >= 7));
      check("dt_overlap", 32'(ctrl && ctrl_n), 32'd0);
    end
    go_idle("dt");
`else
    // 1: basic 10/5 waveform
    cfg_send_idle(10, 5, "t1_cfg");
    enable = 1'b1;
    ph = 9;
    run_cycles(20, 10, 5, "t1");

    // 2: duty change mid-period takes effect at next period
    run_cycles(5, 10, 5, "t2_pre");
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(10);
    cfg_duty   = CNT_W'(3);
    run_cycles(1, 10, 5, "t2_acc");
    cfg_valid = 1'b0;
    check("t2_rdy_low", 32'(cfg_ready), 32'd0);
    run_cycles(4, 10, 5, "t2_old");
    check("t2_rdy_low_end", 32'(cfg_ready), 32'd0);
    check("t2_no_apply_yet", 32'(cfg_applied), 32'd0);
    run_cycles(1, 10, 3, "t2_wrap");
    check("t2_applied", 32'(cfg_applied), 32'd1);
    check("t2_rdy_back", 32'(cfg_ready), 32'd1);
    run_cycles(1, 10, 3, "t2_new");
    check("t2_applied_pulse", 32'(cfg_applied), 32'd0);
    run_cycles(9, 10, 3, "t2_new");

    // 3: back-to-back words, second stalls until first is applied
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(8);
    cfg_duty   = CNT_W'(4);
    run_cycles(1, 10, 3, "t3_accA");
    cfg_period = CNT_W'(6);
    cfg_duty   = CNT_W'(2);
    check("t3_stall", 32'(cfg_ready), 32'd0);
    run_cycles(8, 10, 3, "t3_wait");
    check("t3_stall_end", 32'(cfg_ready), 32'd0);
    run_cycles(1, 10, 4, "t3_applyA");
    check("t3_appliedA", 32'(cfg_applied), 32'd1);
    check("t3_rdyA", 32'(cfg_ready), 32'd1);
    run_cycles(1, 8, 4, "t3_accB");
    cfg_valid = 1'b0;
    check("t3_rdyB_low", 32'(cfg_ready), 32'd0);
    run_cycles(6, 8, 4, "t3_runA");
    run_cycles(1, 8, 2, "t3_applyB");
    check("t3_appliedB", 32'(cfg_applied), 32'd1);
    run_cycles(12, 6, 2, "t3_runB");

    // 4: duty extremes and period clamp
    go_idle("t4a");
    cfg_send_idle(10, 0, "t4a_cfg");
    enable = 1'b1;
    ph = 9;
    run_cycles(12, 10, 0, "t4_duty0");
    go_idle("t4b");
    cfg_send_idle(10, 12, "t4b_cfg");
    enable = 1'b1;
    ph = 9;
    run_cycles(15, 10, 12, "t4_duty_full");
    go_idle("t4c");
    cfg_send_idle(1, 1, "t4c_cfg");
    enable = 1'b1;
    ph = 1;
    run_cycles(8, 2, 1, "t4_per1");

    // 5: reset mid-period with a pending word restores init values
    go_idle("t5");
    cfg_send_idle(10, 5, "t5_cfg");
    enable = 1'b1;
    ph = 9;
    run_cycles(6, 10, 5, "t5_run");
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(4);
    cfg_duty   = CNT_W'(1);
    run_cycles(1, 10, 5, "t5_acc");
    cfg_valid = 1'b0;
    check("t5_pending", 32'(cfg_ready), 32'd0);
    #2 emu_rst = 1'b1;
    #1;
    check("t5_rst_ctrl", 32'(ctrl), 32'd0);
    check("t5_rst_ctrl_n", 32'(ctrl_n), 32'd0);
    check("t5_rst_pstart", 32'(period_start), 32'd0);
    check("t5_rst_ready", 32'(cfg_ready), 32'd1);
    check("t5_rst_applied", 32'(cfg_applied), 32'd0);
    cycle();
    emu_rst = 1'b0;
    ph = 99;
    run_cycles(110, 100, 50, "t5_init");
    check("t5_discarded", 32'(cfg_applied), 32'd0);
    check("t5_ready_after", 32'(cfg_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
